// File: rtl/vicii_pkg.sv
// vicii_pkg: shared constants and types for the VIC-II composite encoder.
//   SYNC_LEVEL / BLANK_LEVEL : DAC codes for sync tip and blanking pedestal
//   LUMA_GAIN                : DAC steps per luma level
//   CHROMA_AMP               : peak subcarrier amplitude (sine table peak)
//   PHASE_W                  : width of a subcarrier phase index (32 steps)
package vicii_pkg;

  localparam int unsigned PHASE_W     = 5;
  localparam logic [7:0]  SYNC_LEVEL  = 8'd0;
  localparam logic [7:0]  BLANK_LEVEL = 8'd64;
  localparam int unsigned LUMA_GAIN   = 4;
  localparam int          CHROMA_AMP  = 24;

  typedef logic [PHASE_W-1:0] phase_t;
  typedef logic signed [5:0]  sine_t;

endpackage

// File: rtl/vicii_sine_lut.sv
// vicii_sine_lut: combinational 32-entry sine table,
// entry k = round(CHROMA_AMP * sin(2*pi*k/32)).
//   idx : phase index 0..31 (11.25 degrees per step)
//   val : signed 6-bit sample
module vicii_sine_lut
  import vicii_pkg::*;
(
  input  phase_t idx,
  output sine_t  val
);

  logic [3:0] pos;
  logic [3:0] mag_idx;
  sine_t      mag;

  // Quarter-wave table: the second quarter mirrors the first, the second
  // half is the negated first half.
  always_comb begin
    pos     = idx[3:0];
    mag_idx = pos[3] ? 4'(5'd16 - {1'b0, pos}) : pos;
    mag     = '0;
    case (mag_idx)
      4'd0:    mag = 6'sd0;
      4'd1:    mag = 6'sd5;
      4'd2:    mag = 6'sd9;
      4'd3:    mag = 6'sd13;
      4'd4:    mag = 6'sd17;
      4'd5:    mag = 6'sd20;
      4'd6:    mag = 6'sd22;
      4'd7:    mag = 6'sd24;
      4'd8:    mag = sine_t'(CHROMA_AMP);
      default: mag = 6'sd0;
    endcase
    val = idx[4] ? -mag : mag;
  end

endmodule

// File: rtl/vicii_composite.sv
// vicii_composite: VIC-II style composite video encoder.
// Two-stage pipeline: stage 1 registers the pixel controls and the
// subcarrier phase index, stage 2 looks up the sine and forms the DAC code.
//   clk, reset_n        : clock, synchronous active-low reset
//   luma, chroma        : brightness 0..31, hue phase index 0..31
//   chroma_en           : enable subcarrier for this pixel
//   sync, blank, burst  : sync tip, blanking, colour-burst window
//   composite           : unsigned 8-bit DAC code, 2 clk after inputs
// Build option VICII_PAL_ALT_EN: PAL line alternation (V-axis inversion of
// chroma and burst phase 12/20 on alternate lines). Without it, chroma is
// used directly and the burst uses BURST_PHASE.
module vicii_composite
  import vicii_pkg::*;
#(
  parameter logic [23:0] PHASE_INC   = 24'd2359362,
  parameter logic [4:0]  BURST_PHASE = 5'd16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] luma,
  input  logic [4:0] chroma,
  input  logic       chroma_en,
  input  logic       sync,
  input  logic       blank,
  input  logic       burst,
  output logic [7:0] composite
);

  logic [23:0] acc;
  phase_t      sub_phase;
  phase_t      eff_chroma;
  phase_t      burst_phase;
  phase_t      phase_sel;

  logic        s1_sync, s1_blank, s1_burst, s1_chroma_en;
  logic [4:0]  s1_luma;
  phase_t      s1_phase;

  sine_t       sine;
  logic signed [8:0] luma_term, chroma_term, half_sine, active_sum, burst_sum;

  assign sub_phase = acc[23:19];

`ifdef VICII_PAL_ALT_EN
  logic line_odd;

  // s1_sync holds the previous sample of sync, so it doubles as the edge
  // detector's delay flop.
  always_ff @(posedge clk) begin
    if (!reset_n)              line_odd <= 1'b0;
    else if (sync && !s1_sync) line_odd <= !line_odd;
  end

  always_comb begin
    eff_chroma  = line_odd ? phase_t'(5'd0 - chroma) : chroma;
    burst_phase = line_odd ? 5'd20 : 5'd12;
  end
`else
  always_comb begin
    eff_chroma  = chroma;
    burst_phase = BURST_PHASE;
  end
`endif

  // Only one phase offset is ever needed per sample, so pick it before the
  // add; the sum wraps mod 32 through the 5-bit width.
  always_comb begin
    phase_sel = sub_phase + ((blank && burst) ? burst_phase : eff_chroma);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc          <= '0;
      s1_sync      <= 1'b0;
      s1_blank     <= 1'b1;
      s1_burst     <= 1'b0;
      s1_chroma_en <= 1'b0;
      s1_luma      <= '0;
      s1_phase     <= '0;
    end else begin
      acc          <= acc + PHASE_INC;
      s1_sync      <= sync;
      s1_blank     <= blank;
      s1_burst     <= burst;
      s1_chroma_en <= chroma_en;
      s1_luma      <= luma;
      s1_phase     <= phase_sel;
    end
  end

  vicii_sine_lut u_lut (
    .idx (s1_phase),
    .val (sine)
  );

  // Result range is 40..212, so the low byte of the 9-bit sum is exact.
  always_comb begin
    luma_term   = 9'(s1_luma * LUMA_GAIN);
    chroma_term = s1_chroma_en ? 9'(sine) : '0;
    half_sine   = 9'(sine >>> 1);
    active_sum  = 9'(BLANK_LEVEL) + luma_term + chroma_term;
    burst_sum   = 9'(BLANK_LEVEL) + half_sine;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)                  composite <= BLANK_LEVEL;
    else if (s1_sync)              composite <= SYNC_LEVEL;
    else if (s1_blank && s1_burst) composite <= burst_sum[7:0];
    else if (s1_blank)             composite <= BLANK_LEVEL;
    else                           composite <= active_sum[7:0];
  end

endmodule

// File: tb/tb_vicii_composite.sv
// tb_vicii_composite: self-checking bench for vicii_composite.
// Two instances share stimulus: dut runs the default subcarrier increment,
// dut0 has PHASE_INC=0 so its sub_phase stays at 0.
module tb_vicii_composite;

  localparam logic [23:0] INC = 24'd2359362;
  localparam logic [4:0]  BP  = 5'd16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] luma, chroma;
  logic       chroma_en, sync, blank, burst;
  logic [7:0] composite, composite0;

  always #5 clk = ~clk;

  vicii_composite #(.PHASE_INC(INC), .BURST_PHASE(BP)) dut (
    .clk(clk), .reset_n(reset_n), .luma(luma), .chroma(chroma),
    .chroma_en(chroma_en), .sync(sync), .blank(blank), .burst(burst),
    .composite(composite)
  );

  vicii_composite #(.PHASE_INC(24'd0), .BURST_PHASE(BP)) dut0 (
    .clk(clk), .reset_n(reset_n), .luma(luma), .chroma(chroma),
    .chroma_en(chroma_en), .sync(sync), .blank(blank), .burst(burst),
    .composite(composite0)
  );

  int total = 0;
  int bad   = 0;
  int wraps = 0;

  // Reference state: model accumulator, line parity, previous sync, and the
  // expected value now on the output / next in flight for each instance.
  logic [23:0] acc_m;
  logic        odd_m, sprev_m;
  int          pend [2];
  int          expo [2];

  function automatic int lut_ref(int k);
    real v;
    v = 24.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 32.0);
    return int'(v);
  endfunction

  function automatic int sample_ref(logic [23:0] acc);
    int sub, ec, bp, s;
    sub = int'(acc) / 524288;
    ec  = int'(chroma);
    bp  = int'(BP);
`ifdef VICII_PAL_ALT_EN
    if (odd_m) ec = (32 - int'(chroma)) % 32;
    bp = odd_m ? 20 : 12;
`endif
    if (sync) return 0;
    if (blank && burst) begin
      s = lut_ref((sub + bp) % 32);
      return 64 + (s >>> 1);
    end
    if (blank) return 64;
    return 64 + 4 * int'(luma) + (chroma_en ? lut_ref((sub + ec) % 32) : 0);
  endfunction

  // Advance one clock, updating the reference with the inputs as sampled.
  task automatic tick();
    logic [23:0] nxt;
    if (!reset_n) begin
      acc_m = '0; odd_m = 1'b0; sprev_m = 1'b0;
      pend[0] = 64; pend[1] = 64; expo[0] = 64; expo[1] = 64;
    end else begin
      expo[0] = pend[0];
      expo[1] = pend[1];
      pend[0] = sample_ref(acc_m);
      pend[1] = sample_ref(24'd0);
      if (sync && !sprev_m) odd_m = !odd_m;
      sprev_m = sync;
      nxt = acc_m + INC;
      if (nxt < acc_m) wraps++;
      acc_m = nxt;
    end
    @(posedge clk);
  endtask

  task automatic randomize_inputs(int sync_pct, int blank_pct);
    luma      = 5'($urandom);
    chroma    = 5'($urandom);
    chroma_en = 1'($urandom);
    sync      = ($urandom_range(99) < sync_pct);
    blank     = ($urandom_range(99) < blank_pct);
    burst     = 1'($urandom);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs(30, 30);
      tick();
      @(negedge clk);
      total++;
      if (composite !== 8'd64 || composite0 !== 8'd64) begin
        bad++;
        $display("FAIL reset_hold: composite=%0d composite0=%0d expected 64", composite, composite0);
      end
    end
    reset_n = 1'b1;
    randomize_inputs(0, 0);
    tick();
    @(negedge clk);
    total++;
    if (composite !== 8'd64 || composite0 !== 8'd64) begin
      bad++;
      $display("FAIL reset_release: composite=%0d composite0=%0d expected 64", composite, composite0);
    end
    tick();
    @(negedge clk);
    total++;
    if (composite !== 8'(expo[0]) || composite0 !== 8'(expo[1])) begin
      bad++;
      $display("FAIL reset_first: composite=%0d/%0d expected %0d/%0d", composite, composite0, expo[0], expo[1]);
    end
  endtask

  task automatic test_sync();
    sync = 1'b1; blank = 1'b0; burst = 1'b0; luma = 5'd31; chroma_en = 1'b1;
    tick(); tick();
    @(negedge clk);
    total++;
    if (composite !== 8'd0 || composite0 !== 8'd0) begin
      bad++;
      $display("FAIL sync_level: composite=%0d composite0=%0d expected 0", composite, composite0);
    end
    sync = 1'b0; blank = 1'b1;
    tick(); tick();
    @(negedge clk);
    total++;
    if (composite !== 8'd64 || composite0 !== 8'd64) begin
      bad++;
      $display("FAIL sync_to_blank: composite=%0d composite0=%0d expected 64", composite, composite0);
    end
  endtask

  task automatic test_grey();
    sync = 1'b0; blank = 1'b0; burst = 1'b0; luma = 5'd20; chroma_en = 1'b0;
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (composite !== 8'd144 || composite0 !== 8'd144) begin
        bad++;
        $display("FAIL grey: composite=%0d composite0=%0d expected 144", composite, composite0);
      end
      chroma = 5'($urandom);
      burst  = 1'($urandom);
      tick();
    end
  endtask

  task automatic test_modulation();
    sync = 1'b0; blank = 1'b0; burst = 1'b0; luma = 5'd8; chroma = 5'd8; chroma_en = 1'b1;
    tick(); tick();
    @(negedge clk);
    total++;
`ifndef VICII_PAL_ALT_EN
    if (composite0 !== 8'd120) begin
      bad++;
      $display("FAIL mod_hue8: composite0=%0d expected 120", composite0);
    end
`else
    if (composite0 !== 8'(expo[1])) begin
      bad++;
      $display("FAIL mod_hue8: composite0=%0d expected %0d", composite0, expo[1]);
    end
`endif
    chroma = 5'd24;
    tick(); tick();
    @(negedge clk);
    total++;
`ifndef VICII_PAL_ALT_EN
    if (composite0 !== 8'd72) begin
      bad++;
      $display("FAIL mod_hue24: composite0=%0d expected 72", composite0);
    end
`else
    if (composite0 !== 8'(expo[1])) begin
      bad++;
      $display("FAIL mod_hue24: composite0=%0d expected %0d", composite0, expo[1]);
    end
`endif
    total++;
    if (composite !== 8'(expo[0])) begin
      bad++;
      $display("FAIL mod_running: composite=%0d expected %0d", composite, expo[0]);
    end
  endtask

  // The default increment wraps the accumulator about every 7 clk, so a
  // run of active pixels crosses 2^24 many times.
  task automatic test_wrap();
    int w0;
    w0 = wraps;
    for (int i = 0; i < 48; i++) begin
      randomize_inputs(0, 0);
      chroma_en = 1'b1;
      tick();
      @(negedge clk);
      total++;
      if (composite !== 8'(expo[0])) begin
        bad++;
        $display("FAIL wrap: cycle=%0d composite=%0d expected %0d", i, composite, expo[0]);
      end
    end
    if (wraps == w0) $display("note: no accumulator wrap seen");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      randomize_inputs(10, 30);
      tick();
      @(negedge clk);
      total++;
      if (composite !== 8'(expo[0]) || composite0 !== 8'(expo[1])) begin
        bad++;
        $display("FAIL random: cycle=%0d composite=%0d/%0d expected %0d/%0d", i, composite, composite0, expo[0], expo[1]);
      end
    end
  endtask

  task automatic test_reset_midline();
    for (int i = 0; i < 10; i++) begin
      randomize_inputs(0, 0);
      tick();
    end
    @(negedge clk);
    reset_n = 1'b0;
    tick();
    @(negedge clk);
    total++;
    if (composite !== 8'd64 || composite0 !== 8'd64) begin
      bad++;
      $display("FAIL midline_reset: composite=%0d composite0=%0d expected 64", composite, composite0);
    end
    reset_n = 1'b1;
    randomize_inputs(0, 0);
    tick();
    @(negedge clk);
    total++;
    if (composite !== 8'd64 || composite0 !== 8'd64) begin
      bad++;
      $display("FAIL midline_flush: composite=%0d composite0=%0d expected 64", composite, composite0);
    end
    for (int i = 0; i < 6; i++) begin
      randomize_inputs(10, 30);
      tick();
      @(negedge clk);
      total++;
      if (composite !== 8'(expo[0]) || composite0 !== 8'(expo[1])) begin
        bad++;
        $display("FAIL midline_resume: cycle=%0d composite=%0d/%0d expected %0d/%0d", i, composite, composite0, expo[0], expo[1]);
      end
    end
  endtask

`ifdef VICII_PAL_ALT_EN
  task automatic test_pal_alt();
    sync = 1'b0; blank = 1'b1; burst = 1'b0;
    tick();
    for (int i = 0; i < 2 && !odd_m; i++) begin
      sync = 1'b1; tick();
      sync = 1'b0; tick();
    end
    sync = 1'b0; blank = 1'b0; burst = 1'b0; luma = 5'd10; chroma = 5'd4; chroma_en = 1'b1;
    tick(); tick();
    @(negedge clk);
    total++;
    if (composite0 !== 8'd87) begin
      bad++;
      $display("FAIL pal_odd_chroma: composite0=%0d expected 87", composite0);
    end
    blank = 1'b1; burst = 1'b1;
    tick(); tick();
    @(negedge clk);
    total++;
    if (composite0 !== 8'd55) begin
      bad++;
      $display("FAIL pal_burst_odd: composite0=%0d expected 55", composite0);
    end
    burst = 1'b0; sync = 1'b1; tick();
    sync = 1'b0; burst = 1'b1;
    tick(); tick();
    @(negedge clk);
    total++;
    if (composite0 !== 8'd72) begin
      bad++;
      $display("FAIL pal_burst_even: composite0=%0d expected 72", composite0);
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    luma = '0; chroma = '0; chroma_en = 1'b0;
    sync = 1'b0; blank = 1'b0; burst = 1'b0;
    acc_m = '0; odd_m = 1'b0; sprev_m = 1'b0;
    pend[0] = 64; pend[1] = 64; expo[0] = 64; expo[1] = 64;
    test_reset();
    test_sync();
    test_grey();
    test_modulation();
    test_wrap();
    test_random();
    test_reset_midline();
`ifdef VICII_PAL_ALT_EN
    test_pal_alt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
